sram_mem_controller: RTL and testbench
======================================

# sram_mem_controller

Sequences MEM-stage loads and stores of the ARM pipeline onto an external 16-bit asynchronous SRAM. Each 32-bit word is split into two half-word accesses with a programmable number of wait cycles per half. While an access is in flight, `ready` stays low; its inverse drives the pipeline-wide freeze, so the IF/ID/EXE/MEM stage registers hold until the word transfer completes.

## Interface
- `BASE_ADDR`, default 1024: first data-memory byte address; mapped to SRAM half-word 0.
- `WAIT_CYCLES`, default 2: cycles per half-word phase. Legal values are 1..15.
- `SRAM_AW`, default 18: SRAM address width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rd_en`  in  1  MEM-stage load request (`MEM_R_EN`).
- `wr_en`  in  1  MEM-stage store request (`MEM_W_EN`).
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (`Val_Rm`).
- `read_data`  out  32  load result. Registered; holds its value between loads.
- `ready`  out  1  combinational: `~(rd_en|wr_en) | (state==DONE)`. Pipeline freeze is `~ready`.
- `sram_addr`  out  SRAM_AW  half-word address.
- `sram_dq_out`  out  16  write data to the pad.
- `sram_dq_oe`  out  1  pad output enable.
- `sram_dq_in`  in  16  read data from the pad.
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- Word index: `idx = (address - BASE_ADDR) >> 2`, arithmetic modulo 2^32, truncated to SRAM_AW-1 bits.
  - Low half is at `{idx,1'b0}`; high half is at `{idx,1'b1}`.
- Write priority: if `rd_en` and `wr_en` are both high, the access is a write.
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter `cnt` (4 bits) runs in LOW and HIGH.
- IDLE
  - If `rd_en|wr_en`: latch the op (write/read), `idx` and `write_data`; set `cnt=0`; go to LOW.
  - Otherwise stay in IDLE.
- LOW
  - Drive `sram_addr={idx,0}`.
  - Write: `sram_dq_out=wdata[15:0]`, `sram_dq_oe=1`, `sram_we_n=0`.
  - Read: `sram_dq_oe=0`, `sram_we_n=1`.
  - `cnt` increments each cycle.
  - When `cnt==WAIT_CYCLES-1`: on a read, capture `read_data[15:0]<=sram_dq_in`; set `cnt=0`; go to HIGH.
- HIGH
  - Same as LOW with `{idx,1}` and `wdata[31:16]`.
  - At the terminal count, a read captures `read_data[31:16]`; go to DONE.
- DONE: one cycle with `ready=1`. SRAM is idle (`we_n=1`, `oe=0`). Go to IDLE unconditionally.
- Latched op, address and data are used for the whole transaction. Input changes or request deassertion mid-transaction are ignored; the transaction always completes.
- Idle outputs: `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`.
- `read_data` changes only at half-word capture points. It is never altered by writes.

## Timing
- Reset, synchronous at a rising edge with `rst=1`:
  - state returns to IDLE, `cnt=0`, `read_data=0`, latched op/addr/data cleared.
  - SRAM outputs go to idle values on the following cycle.
  - `ready` follows its combinational equation.
- Reset mid-transaction aborts it. A write may leave only the low half written. No DONE cycle occurs.
- Latency: with the request present in cycle 0 (IDLE), `ready=0` for cycles 0..2·WAIT_CYCLES. `ready=1` in cycle 2·WAIT_CYCLES+1 (DONE).
  - Default parameters: low in cycles 0–4, high in cycle 5. The pipeline advances at the end of cycle 5.
- `read_data` holds the full word from DONE onward. The MEM stage register samples it at the end of the DONE cycle.
- Back-to-back: a request present in the cycle after DONE starts a new transaction from IDLE. Two consecutive accesses therefore take 2·(2·WAIT_CYCLES+2) cycles.
- No request: `ready=1` every cycle and the FSM stays in IDLE. No freeze is inserted.
- `WAIT_CYCLES=1`: LOW and HIGH last one cycle each; `ready` is low for 3 cycles.

## Test plan
- Reset: assert `rst` with `rd_en=1` mid-LOW.
  - Next cycle: state IDLE, `read_data=0`, `sram_we_n=1`, `sram_dq_oe=0`.
  - Transaction restarts after `rst` drops.
- Store: `wr_en=1`, `address=1024`, `write_data=0xDEADBEEF`, defaults.
  - SRAM model holds 0xBEEF at 0 and 0xDEAD at 1.
  - `ready` is low for 5 cycles, high on the 6th.
  - `sram_we_n` is low exactly 4 cycles.
- Load: `rd_en=1`, `address=1024` after the store.
  - `read_data=0xDEADBEEF` in DONE and held afterwards.
  - `sram_dq_oe` stays 0 throughout.
- Mapping: store 0x12345678 at address 1032.
  - SRAM half-word 4 = 0x5678, half-word 5 = 0x1234.
  - Load from 1036 returns the prior contents of 6/7.
- Conflict and mid-op changes: `rd_en=wr_en=1` at 1040 with data 0xCAFEF00D.
  - A write occurs.
  - Changing `address` and `write_data` in cycle 2 has no effect on the transaction.
- Back-to-back with `WAIT_CYCLES=1`: a load immediately follows a store.
  - `ready` pattern is 0,0,0,1,0,0,0,1.
  - The load returns the stored word.

Source files
------------

// File: rtl/sram_mem_controller_if.sv
// sram_mem_controller_if: MEM-stage request/response bus plus 16-bit async SRAM pad signals.
interface sram_mem_controller_if #(parameter int SRAM_AW = 18);
   logic               rd_en;
   logic               wr_en;
   logic [31:0]        address;
   logic [31:0]        write_data;
   logic [31:0]        read_data;
   logic               ready;
   logic [SRAM_AW-1:0] sram_addr;
   logic [15:0]        sram_dq_out;
   logic               sram_dq_oe;
   logic [15:0]        sram_dq_in;
   logic               sram_we_n;
   modport master (
      output rd_en, wr_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
   modport slave (
      input  rd_en, wr_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: splits 32-bit MEM-stage loads/stores into two timed half-word SRAM accesses.
module sram_mem_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 18
) (
   input logic                clk,
   input logic                rst,
   sram_mem_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
   state_t             state, state_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic               op_wr;
   logic [SRAM_AW-2:0] idx, idx_in;
   logic [31:0]        wdata, rdata;
   logic               req, term, active, drive;
   assign req    = bus.rd_en | bus.wr_en;
   assign term   = cnt == 4'(WAIT_CYCLES - 1);
   assign idx_in = (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);
   assign active = (state == LOW) || (state == HIGH);
   assign drive  = active && op_wr;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         op_wr <= 1'b0;
         idx   <= '0;
         wdata <= '0;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req) begin
            op_wr <= bus.wr_en;
            idx   <= idx_in;
            wdata <= bus.write_data;
         end
         if (state == LOW && term && !op_wr) rdata[15:0] <= bus.sram_dq_in;
         if (state == HIGH && term && !op_wr) rdata[31:16] <= bus.sram_dq_in;
      end
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            state_nxt = req ? LOW : IDLE;
            cnt_nxt   = '0;
         end
         LOW: begin
            state_nxt = term ? HIGH : LOW;
            cnt_nxt   = term ? 4'd0 : cnt + 4'd1;
         end
         HIGH: begin
            state_nxt = term ? DONE : HIGH;
            cnt_nxt   = term ? 4'd0 : cnt + 4'd1;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end
   assign bus.ready       = ~req | (state == DONE);
   assign bus.read_data   = rdata;
   assign bus.sram_addr   = active ? {idx, state == HIGH} : '0;
   assign bus.sram_dq_out = drive ? ((state == HIGH) ? wdata[31:16] : wdata[15:0]) : 16'h0;
   assign bus.sram_dq_oe  = drive;
   assign bus.sram_we_n   = ~drive;
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: scoreboard bench with SRAM models for a default and a single-wait-cycle controller.
module tb_sram_mem_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  pat;
   logic [15:0] mem_a [0:63];
   logic [15:0] mem_b [0:63];

   always #5 clk = ~clk;

   sram_mem_controller_if #(.SRAM_AW(18)) ai ();
   sram_mem_controller_if #(.SRAM_AW(18)) bi ();

   sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2), .SRAM_AW(18)) dut_a (.clk(clk), .rst(rst), .bus(ai));
   sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut_b (.clk(clk), .rst(rst), .bus(bi));

   assign ai.sram_dq_in = mem_a[ai.sram_addr[5:0]];
   assign bi.sram_dq_in = mem_b[bi.sram_addr[5:0]];

   always @(posedge clk) begin
      if (!ai.sram_we_n) mem_a[ai.sram_addr[5:0]] <= ai.sram_dq_out;
      if (!bi.sram_we_n) mem_b[bi.sram_addr[5:0]] <= bi.sram_dq_out;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input bit sel, input logic rd, input logic wr, input logic [31:0] ad, input logic [31:0] wd);
      if (sel) begin
         bi.rd_en = rd; bi.wr_en = wr; bi.address = ad; bi.write_data = wd;
      end else begin
         ai.rd_en = rd; ai.wr_en = wr; ai.address = ad; ai.write_data = wd;
      end
   endtask

   // Called just after a rising edge; returns just after the edge that ends DONE, request still driven.
   task automatic access(input bit sel, input logic rd, input logic wr, input logic [31:0] ad,
                         input logic [31:0] wd, input bit mut, input int exp_low);
      int   low = 0;
      int   we_lo = 0;
      int   oe_hi = 0;
      logic r = 1'b0;
      logic [31:0] exp;
      set_req(sel, rd, wr, ad, wd);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         r = sel ? bi.ready : ai.ready;
         pat = {pat[6:0], r};
         if (!(sel ? bi.sram_we_n : ai.sram_we_n)) we_lo++;
         if (sel ? bi.sram_dq_oe : ai.sram_dq_oe) oe_hi++;
         if (r) break;
         low++;
         @(posedge clk); #1;
         if (mut && c == 1) set_req(sel, rd, wr, 32'd1024, 32'h0BADBEEF);
      end
      check("ready_done", {31'd0, r}, 32'd1);
      check("ready_low_cycles", low, exp_low);
      check("we_n_low_cycles", we_lo, wr ? exp_low - 1 : 0);
      check("dq_oe_cycles", oe_hi, wr ? exp_low - 1 : 0);
      if (rd && !wr) begin
         if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
         else begin
            exp = exp_q.pop_front();
            check("read_data", sel ? bi.read_data : ai.read_data, exp);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_a[i] = 16'h0;
         mem_b[i] = 16'h0;
      end
      mem_a[6] = 16'hA5A5;
      mem_a[7] = 16'h3C3C;
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_ready", {31'd0, ai.ready}, 32'd1);
      check("idle_read_data", ai.read_data, 32'd0);
      check("idle_we_n", {31'd0, ai.sram_we_n}, 32'd1);
      check("idle_oe", {31'd0, ai.sram_dq_oe}, 32'd0);
      check("idle_addr", {14'd0, ai.sram_addr}, 32'd0);
      @(posedge clk); #1;
      access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 5);
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("store_lo", {16'd0, mem_a[0]}, 32'h0000BEEF);
      check("store_hi", {16'd0, mem_a[1]}, 32'h0000DEAD);
      @(posedge clk); #1;
      exp_q.push_back(32'hDEADBEEF);
      access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 5);
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1 check("read_hold", ai.read_data, 32'hDEADBEEF);
      set_req(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_read_data", ai.read_data, 32'd0);
      check("rst_we_n", {31'd0, ai.sram_we_n}, 32'd1);
      check("rst_oe", {31'd0, ai.sram_dq_oe}, 32'd0);
      check("rst_addr", {14'd0, ai.sram_addr}, 32'd0);
      rst = 1'b0;
      exp_q.push_back(32'hDEADBEEF);
      access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 5);
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 1'b0, 5);
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("map_lo", {16'd0, mem_a[4]}, 32'h00005678);
      check("map_hi", {16'd0, mem_a[5]}, 32'h00001234);
      check("write_keeps_read_data", ai.read_data, 32'hDEADBEEF);
      @(posedge clk); #1;
      exp_q.push_back(32'h3C3CA5A5);
      access(1'b0, 1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 5);
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      access(1'b0, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b1, 5);
      set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("conflict_lo", {16'd0, mem_a[8]}, 32'h0000F00D);
      check("conflict_hi", {16'd0, mem_a[9]}, 32'h0000CAFE);
      check("midop_addr_lo", {16'd0, mem_a[0]}, 32'h0000BEEF);
      check("midop_addr_hi", {16'd0, mem_a[1]}, 32'h0000DEAD);
      check("conflict_read_data", ai.read_data, 32'h3C3CA5A5);
      @(posedge clk); #1;
      pat = 8'hFF;
      access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h11223344, 1'b0, 3);
      exp_q.push_back(32'h11223344);
      access(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 3);
      set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      check("b2b_ready_pattern", {24'd0, pat}, 32'h00000011);
      check("b2b_mem_lo", {16'd0, mem_b[2]}, 32'h00003344);
      check("b2b_mem_hi", {16'd0, mem_b[3]}, 32'h00001122);
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
